// File: rtl/tl_fc_credit_gate.sv
// rtl/tl_fc_credit_gate.sv - TX flow-control credit gate: per-VC FC limits, consumed credits, modulo admit check
module tl_fc_credit_gate #(
    parameter int HDR_W  = 8,
    parameter int DAT_W  = 12,
    parameter int NUM_VC = 1,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic              fc_valid,
    input  logic              fc_init,
    input  logic [VC_W-1:0]   fc_vc,
    input  logic [1:0]        fc_cls,
    input  logic [HDR_W-1:0]  fc_hdr,
    input  logic [DAT_W-1:0]  fc_dat,
    input  logic              req_valid,
    input  logic [VC_W-1:0]   req_vc,
    input  logic [1:0]        req_cls,
    input  logic              req_has_data,
    input  logic [9:0]        req_len,
    output logic              req_ready,
    output logic [NUM_VC-1:0] vc_active,
    output logic              fc_err
);

    typedef enum logic [1:0] {
        VC_UNINIT,
        VC_INIT,
        VC_ACTIVE
    } vc_state_t;

    localparam logic [HDR_W-1:0] HDR_HALF = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DAT_W-1:0] DAT_HALF = {1'b1, {(DAT_W-1){1'b0}}};
    localparam logic [VC_W:0]    NUM_VC_L = (VC_W+1)'(NUM_VC);

    vc_state_t        state_q [NUM_VC];
    vc_state_t        state_d [NUM_VC];
    logic [2:0]       seen_q  [NUM_VC];
    logic [2:0]       seen_d  [NUM_VC];
    logic [2:0]       hinf_q  [NUM_VC];
    logic [2:0]       hinf_d  [NUM_VC];
    logic [2:0]       dinf_q  [NUM_VC];
    logic [2:0]       dinf_d  [NUM_VC];
    logic [HDR_W-1:0] hlim_q  [NUM_VC][3];
    logic [HDR_W-1:0] hlim_d  [NUM_VC][3];
    logic [HDR_W-1:0] hcons_q [NUM_VC][3];
    logic [HDR_W-1:0] hcons_d [NUM_VC][3];
    logic [DAT_W-1:0] dlim_q  [NUM_VC][3];
    logic [DAT_W-1:0] dlim_d  [NUM_VC][3];
    logic [DAT_W-1:0] dcons_q [NUM_VC][3];
    logic [DAT_W-1:0] dcons_d [NUM_VC][3];
    logic             fc_err_q;
    logic             fc_err_d;

    logic             fc_vc_ok;
    logic [10:0]      len_dw;
    logic [10:0]      len_cr;
    logic [DAT_W-1:0] dat_need;
    logic             sel_active;
    logic             sel_hinf;
    logic             sel_dinf;
    logic [HDR_W-1:0] sel_hlim;
    logic [HDR_W-1:0] sel_hcons;
    logic [DAT_W-1:0] sel_dlim;
    logic [DAT_W-1:0] sel_dcons;
    logic [HDR_W-1:0] hdr_diff;
    logic [DAT_W-1:0] dat_diff;
    logic             hdr_ok;
    logic             dat_ok;

    assign fc_vc_ok = {1'b0, fc_vc} < NUM_VC_L;
    assign len_dw   = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
    assign len_cr   = (len_dw + 11'd3) >> 2;
    assign dat_need = req_has_data ? DAT_W'(len_cr) : '0;

    // An out-of-range VC or the reserved class matches no entry, so it is never active.
    always_comb begin
        sel_active = 1'b0;
        sel_hinf   = 1'b0;
        sel_dinf   = 1'b0;
        sel_hlim   = '0;
        sel_hcons  = '0;
        sel_dlim   = '0;
        sel_dcons  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            for (int c = 0; c < 3; c++) begin
                if (req_vc == VC_W'(v) && req_cls == 2'(c)) begin
                    sel_active = (state_q[v] == VC_ACTIVE);
                    sel_hinf   = hinf_q[v][c];
                    sel_dinf   = dinf_q[v][c];
                    sel_hlim   = hlim_q[v][c];
                    sel_hcons  = hcons_q[v][c];
                    sel_dlim   = dlim_q[v][c];
                    sel_dcons  = dcons_q[v][c];
                end
            end
        end
    end

    assign hdr_diff  = sel_hlim - sel_hcons - HDR_W'(1);
    assign dat_diff  = sel_dlim - sel_dcons - dat_need;
    assign hdr_ok    = sel_hinf | (hdr_diff <= HDR_HALF);
    assign dat_ok    = sel_dinf | (dat_diff <= DAT_HALF);
    assign req_ready = req_valid & link_up & sel_active & hdr_ok & dat_ok;
    assign fc_err    = fc_err_q;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_active[v] = (state_q[v] == VC_ACTIVE);
        end
    end

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        hinf_d   = hinf_q;
        dinf_d   = dinf_q;
        hlim_d   = hlim_q;
        hcons_d  = hcons_q;
        dlim_d   = dlim_q;
        dcons_d  = dcons_q;
        fc_err_d = fc_err_q;

        if (link_up && fc_valid) begin
            if (!fc_vc_ok) begin
                fc_err_d = 1'b1;
            end else if (fc_cls != 2'd3) begin
                for (int v = 0; v < NUM_VC; v++) begin
                    for (int c = 0; c < 3; c++) begin
                        if (fc_vc == VC_W'(v) && fc_cls == 2'(c)) begin
                            if (fc_init) begin
                                if (state_q[v] != VC_ACTIVE && !seen_q[v][c]) begin
                                    hlim_d[v][c] = fc_hdr;
                                    dlim_d[v][c] = fc_dat;
                                    hinf_d[v][c] = (fc_hdr == '0);
                                    dinf_d[v][c] = (fc_dat == '0);
                                    seen_d[v][c] = 1'b1;
                                    state_d[v]   = (seen_d[v] == 3'b111) ? VC_ACTIVE : VC_INIT;
                                end
                            end else if (state_q[v] == VC_ACTIVE) begin
                                // An infinite field stays infinite; a nonzero update to it is a protocol error.
                                if (hinf_q[v][c]) begin
                                    if (fc_hdr != '0) fc_err_d = 1'b1;
                                end else begin
                                    hlim_d[v][c] = fc_hdr;
                                end
                                if (dinf_q[v][c]) begin
                                    if (fc_dat != '0) fc_err_d = 1'b1;
                                end else begin
                                    dlim_d[v][c] = fc_dat;
                                end
                            end else begin
                                fc_err_d = 1'b1;
                            end
                        end
                    end
                end
            end
        end

        if (req_ready) begin
            for (int v = 0; v < NUM_VC; v++) begin
                for (int c = 0; c < 3; c++) begin
                    if (req_vc == VC_W'(v) && req_cls == 2'(c)) begin
                        if (!hinf_q[v][c]) hcons_d[v][c] = hcons_q[v][c] + HDR_W'(1);
                        if (!dinf_q[v][c]) dcons_d[v][c] = dcons_q[v][c] + dat_need;
                    end
                end
            end
        end

        if (!link_up) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_d[v] = VC_UNINIT;
                seen_d[v]  = '0;
                hinf_d[v]  = '0;
                dinf_d[v]  = '0;
                for (int c = 0; c < 3; c++) begin
                    hlim_d[v][c]  = '0;
                    hcons_d[v][c] = '0;
                    dlim_d[v][c]  = '0;
                    dcons_d[v][c] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= VC_UNINIT;
            end
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                seen_q[v] <= '0;
                hinf_q[v] <= '0;
                dinf_q[v] <= '0;
                for (int c = 0; c < 3; c++) begin
                    hlim_q[v][c]  <= '0;
                    hcons_q[v][c] <= '0;
                    dlim_q[v][c]  <= '0;
                    dcons_q[v][c] <= '0;
                end
            end
        end else begin
            fc_err_q <= fc_err_d;
            seen_q   <= seen_d;
            hinf_q   <= hinf_d;
            dinf_q   <= dinf_d;
            hlim_q   <= hlim_d;
            hcons_q  <= hcons_d;
            dlim_q   <= dlim_d;
            dcons_q  <= dcons_d;
        end
    end

endmodule

// File: tb/tb_tl_fc_credit_gate.sv
// tb/tb_tl_fc_credit_gate.sv - scoreboard bench for tl_fc_credit_gate against an arithmetic credit model
module tb_tl_fc_credit_gate;

    localparam int HDR_W  = 8;
    localparam int DAT_W  = 12;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              link_up;
    logic              fc_valid;
    logic              fc_init;
    logic [VC_W-1:0]   fc_vc;
    logic [1:0]        fc_cls;
    logic [HDR_W-1:0]  fc_hdr;
    logic [DAT_W-1:0]  fc_dat;
    logic              req_valid;
    logic [VC_W-1:0]   req_vc;
    logic [1:0]        req_cls;
    logic              req_has_data;
    logic [9:0]        req_len;
    logic              req_ready;
    logic [NUM_VC-1:0] vc_active;
    logic              fc_err;

    tl_fc_credit_gate #(.HDR_W(HDR_W), .DAT_W(DAT_W), .NUM_VC(NUM_VC)) dut (
        .clk(clk), .rst(rst), .link_up(link_up),
        .fc_valid(fc_valid), .fc_init(fc_init), .fc_vc(fc_vc), .fc_cls(fc_cls),
        .fc_hdr(fc_hdr), .fc_dat(fc_dat),
        .req_valid(req_valid), .req_vc(req_vc), .req_cls(req_cls),
        .req_has_data(req_has_data), .req_len(req_len), .req_ready(req_ready),
        .vc_active(vc_active), .fc_err(fc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rdy;
        bit [3:0] act;
        bit       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   last_g;

    // Reference model: state 0 = uninit, 1 = init, 2 = active; credits held as plain ints.
    int m_st [4];
    bit m_seen [4][3];
    int m_lh [4][3];
    int m_ld [4][3];
    int m_ch [4][3];
    int m_cd [4][3];
    bit m_ih [4][3];
    bit m_id [4][3];
    bit m_err;

    task automatic clear_vc(int v);
        m_st[v] = 0;
        for (int c = 0; c < 3; c++) begin
            m_seen[v][c] = 0; m_lh[v][c] = 0; m_ld[v][c] = 0;
            m_ch[v][c] = 0; m_cd[v][c] = 0; m_ih[v][c] = 0; m_id[v][c] = 0;
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++) clear_vc(v);
        m_err = 0;
    endtask

    function automatic int need_d();
        if (!req_has_data) return 0;
        if (req_len == 0) return 256;
        return (int'(req_len) + 3) / 4;
    endfunction

    function automatic bit fits(int lim, int cons, int need, int w);
        int m = 1 << w;
        int d = ((lim - cons - need) % m + m) % m;
        return d <= m / 2;
    endfunction

    function automatic bit m_ready();
        int v = int'(req_vc);
        int c = int'(req_cls);
        if (rst || !req_valid || !link_up || c == 3) return 0;
        if (m_st[v] != 2) return 0;
        return (m_ih[v][c] || fits(m_lh[v][c], m_ch[v][c], 1, HDR_W)) &&
               (m_id[v][c] || fits(m_ld[v][c], m_cd[v][c], need_d(), DAT_W));
    endfunction

    task automatic model_edge(bit g);
        int v, c;
        if (rst) begin model_reset(); return; end
        if (!link_up) begin
            for (int i = 0; i < 4; i++) clear_vc(i);
            return;
        end
        if (fc_valid && fc_cls != 3) begin
            v = int'(fc_vc); c = int'(fc_cls);
            if (fc_init) begin
                if (m_st[v] != 2 && !m_seen[v][c]) begin
                    m_lh[v][c] = int'(fc_hdr); m_ld[v][c] = int'(fc_dat);
                    m_ih[v][c] = (fc_hdr == 0); m_id[v][c] = (fc_dat == 0);
                    m_seen[v][c] = 1;
                    m_st[v] = (m_seen[v][0] && m_seen[v][1] && m_seen[v][2]) ? 2 : 1;
                end
            end else if (m_st[v] == 2) begin
                if (m_ih[v][c]) m_err = m_err | (fc_hdr != 0); else m_lh[v][c] = int'(fc_hdr);
                if (m_id[v][c]) m_err = m_err | (fc_dat != 0); else m_ld[v][c] = int'(fc_dat);
            end else begin
                m_err = 1;
            end
        end
        if (g) begin
            v = int'(req_vc); c = int'(req_cls);
            if (!m_ih[v][c]) m_ch[v][c] = (m_ch[v][c] + 1) % (1 << HDR_W);
            if (!m_id[v][c]) m_cd[v][c] = (m_cd[v][c] + need_d()) % (1 << DAT_W);
        end
    endtask

    task automatic step();
        exp_t e;
        if (rst) model_reset();
        e.rdy = m_ready();
        e.act = {m_st[3] == 2, m_st[2] == 2, m_st[1] == 2, m_st[0] == 2};
        e.err = m_err;
        sb.push_back(e);
        last_g = e.rdy;
        @(posedge clk);
        model_edge(e.rdy);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("req_ready", int'(req_ready), int'(e.rdy));
            chk("vc_active", int'(vc_active), int'(e.act));
            chk("fc_err", int'(fc_err), int'(e.err));
        end
    end

    task automatic clr_fc();
        fc_valid = 0; fc_init = 0; fc_vc = 0; fc_cls = 0; fc_hdr = 0; fc_dat = 0;
    endtask

    task automatic fc(bit init, int vc, int cls, int hdr, int dat);
        fc_valid = 1; fc_init = init; fc_vc = 2'(vc); fc_cls = 2'(cls);
        fc_hdr = 8'(hdr); fc_dat = 12'(dat);
        step();
        clr_fc();
    endtask

    task automatic req(int vc, int cls, bit hd, int len);
        req_valid = 1; req_vc = 2'(vc); req_cls = 2'(cls); req_has_data = hd; req_len = 10'(len);
    endtask

    task automatic req_off();
        req_valid = 0;
    endtask

    task automatic init_vc(int v, int ph, int pd, int nh, int nd, int ch, int cd);
        fc(1, v, 0, ph, pd);
        fc(1, v, 1, nh, nd);
        fc(1, v, 2, ch, cd);
    endtask

    // Raise P limits on VC0 exactly enough for one request of len, then send it.
    task automatic feed(int len);
        int n = (len == 0) ? 256 : (len + 3) / 4;
        fc(0, 0, 0, (m_ch[0][0] + 1) % 256, (m_cd[0][0] + n) % 4096);
        req(0, 0, 1, len);
        step();
        req_off();
    endtask

    task automatic pulse_reset();
        rst = 1; step(); step(); rst = 0; step();
    endtask

    initial begin
        bit pend;
        int stall, v, k;
        rst = 1; link_up = 0; clr_fc(); req_off();
        req_vc = 0; req_cls = 0; req_has_data = 0; req_len = 0;
        model_reset();
        @(posedge clk); #1;
        step();
        req(0, 0, 1, 16); step(); req_off();
        rst = 0; step();
        link_up = 1; step();

        // Basic grant/hold, then same-cycle UpdateFC still judged on the old limit.
        init_vc(0, 4, 8, 2, 2, 0, 0);
        step();
        req(0, 0, 1, 16);
        repeat (5) step();
        fc(0, 0, 0, 4, 16);
        step();
        req_off(); step();

        // Infinite CPL credits.
        req(0, 2, 1, 0);
        repeat (300) step();
        fc(0, 0, 2, 5, 0);
        repeat (3) step();
        req_off(); step();

        // Drive PD consumed to 4094, then wrap.
        repeat (15) feed(0);
        feed(968);
        feed(16);
        req(0, 0, 1, 16); repeat (2) step();
        fc(0, 0, 0, (m_ch[0][0] + 1) % 256, 6);
        step(); req_off(); step();

        // Link drop mid-stream, then re-init restarts consumed from zero.
        fc(0, 0, 0, 200, 200);
        req(0, 0, 1, 16); repeat (2) step();
        link_up = 0; step(); step();
        link_up = 1; step();
        init_vc(0, 10, 4, 1, 1, 1, 1);
        repeat (2) step();
        req_off();

        req(0, 3, 0, 4); repeat (2) step(); req_off();

        // Multi-VC: only VC2 initialised.
        pulse_reset();
        init_vc(2, 3, 3, 3, 3, 3, 3);
        req(0, 0, 1, 4); repeat (4) step(); req_off();
        req(2, 0, 1, 4); step(); req_off();
        fc(0, 0, 0, 5, 5);
        step();

        // Randomised traffic.
        pulse_reset();
        link_up = 1;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++)
                fc(1, i, c, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095));
        pend = 0; stall = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            clr_fc();
            if (!link_up) link_up = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 399) == 0) link_up = 0;
            if (!pend && $urandom_range(0, 9) < 7) begin
                req($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1023));
                pend = 1; stall = 0;
            end
            if (pend && stall > 12) begin
                v = int'(req_vc); k = int'(req_cls);
                if (m_st[v] != 2) begin
                    for (int c = 2; c >= 0; c--) if (!m_seen[v][c]) k = c;
                    fc_valid = 1; fc_init = 1; fc_vc = req_vc; fc_cls = 2'(k);
                    fc_hdr = 8'($urandom_range(1, 255)); fc_dat = 12'($urandom_range(1, 4095));
                end else begin
                    fc_valid = 1; fc_init = 0; fc_vc = req_vc; fc_cls = req_cls;
                    fc_hdr = m_ih[v][k] ? 8'd0 : 8'((m_ch[v][k] + 1 + $urandom_range(0, 100)) % 256);
                    fc_dat = m_id[v][k] ? 12'd0 :
                             12'((m_cd[v][k] + need_d() + $urandom_range(0, 100)) % 4096);
                end
            end else if ($urandom_range(0, 4) == 0) begin
                fc_valid = 1; fc_init = ($urandom_range(0, 3) == 0);
                fc_vc = 2'($urandom_range(0, 3)); fc_cls = 2'($urandom_range(0, 3));
                fc_hdr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                fc_dat = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
            end
            step();
            if (last_g) begin
                pend = 0; req_off();
            end else if (pend) begin
                stall++;
            end
        end
        clr_fc(); req_off();
        repeat (3) step();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
